// File: rtl/led_flow_if.sv
// Control and display signals between the LED flow sequencer and its host.
// The host drives the level controls and step_req; the sequencer drives the registered LED outputs.
interface led_flow_if;
  logic       enable;
  logic       dir;
  logic       bounce_en;
  logic       step_req;
  logic [7:0] led_select;
  logic       step_pulse;
  logic       wrap_pulse;

  modport master (
    output enable, dir, bounce_en, step_req,
    input  led_select, step_pulse, wrap_pulse
  );

  modport slave (
    input  enable, dir, bounce_en, step_req,
    output led_select, step_pulse, wrap_pulse
  );
endinterface

// File: rtl/led_flow_sequencer.sv
// Moves a one-hot LED head around 8 positions, stepping once per divider period while running,
// or once per step_req while idle. Supports wrap-around or ping-pong at the ends.
module led_flow_sequencer #(
  parameter logic [23:0] DIV_MAX = 24'd5_999_999
) (
  input  logic        clk,
  input  logic        rst_n,
  led_flow_if.slave   bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_REV  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_pos;
  logic [2:0]  w_pos_nxt;
  logic [23:0] r_cnt;
  logic [23:0] w_cnt_nxt;
  logic [7:0]  r_led;
  logic        r_step_pulse;
  logic        r_wrap_pulse;
  logic        w_tick;
  logic        w_step_en;
  logic        w_step_fwd;
  logic        w_wrap;

  assign w_tick = (r_cnt == DIV_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_en   = 1'b0;
    w_step_fwd  = 1'b1;
    w_pos_nxt   = r_pos;
    w_wrap      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 24'd0;
        if (bus.enable) begin
          w_state_nxt = bus.dir ? S_REV : S_FWD;
        end else if (bus.step_req) begin
          w_step_en  = 1'b1;
          w_step_fwd = !bus.dir;
        end
      end
      S_FWD, S_REV: begin
        // Dropping enable wins over a coincident tick: no step on the way to IDLE.
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 24'd0;
        end else if (w_tick) begin
          w_cnt_nxt  = 24'd0;
          w_step_en  = 1'b1;
          w_step_fwd = bus.bounce_en ? (r_state == S_FWD) : !bus.dir;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 24'd0;
      end
    endcase

    if (w_step_en) begin
      if (w_step_fwd) begin
        if (r_pos == 3'd7) begin
          w_wrap    = 1'b1;
          w_pos_nxt = bus.bounce_en ? 3'd6 : 3'd0;
        end else begin
          w_pos_nxt = r_pos + 3'd1;
        end
      end else begin
        if (r_pos == 3'd0) begin
          w_wrap    = 1'b1;
          w_pos_nxt = bus.bounce_en ? 3'd1 : 3'd7;
        end else begin
          w_pos_nxt = r_pos - 3'd1;
        end
      end
    end

    // A manual step in IDLE never changes state, so bounce reversal is only remembered while running.
    if (w_step_en && (r_state != S_IDLE)) begin
      if (bus.bounce_en) begin
        if (w_wrap) begin
          w_state_nxt = w_step_fwd ? S_REV : S_FWD;
        end
      end else begin
        w_state_nxt = w_step_fwd ? S_FWD : S_REV;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pos        <= 3'd0;
      r_cnt        <= 24'd0;
      r_led        <= 8'h01;
      r_step_pulse <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_cnt        <= w_cnt_nxt;
      r_led        <= 8'h01 << w_pos_nxt;
      r_step_pulse <= w_step_en;
      r_wrap_pulse <= w_wrap;
    end
  end

  assign bus.led_select = r_led;
  assign bus.step_pulse = r_step_pulse;
  assign bus.wrap_pulse = r_wrap_pulse;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_led_flow_sequencer.sv
// Directed scenarios plus randomized control traffic, scored against a position/direction model
// that reasons in signed steps and cycles-to-next-tick.
module tb_led_flow_sequencer;
  localparam int DIV = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;

  logic [9:0] exp_q[$];

  // Reference model: head position, signed direction, and cycles left before the next tick.
  int m_pos;
  int m_dir;
  int m_left;
  bit m_run;
  bit m_step;
  bit m_wrap;

  led_flow_if bus ();

  led_flow_sequencer #(.DIV_MAX(24'd3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic move(input int d_in, output int d_out);
    int np;
    int d;
    d  = d_in;
    np = m_pos + d;
    if (np < 0 || np > 7) begin
      m_wrap = 1'b1;
      if (bus.bounce_en) begin
        d  = -d;
        np = m_pos + d;
      end else begin
        np = (np + 8) % 8;
      end
    end
    m_pos  = np;
    m_step = 1'b1;
    d_out  = d;
  endtask

  task automatic model_edge();
    int d;
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (!m_run) begin
      if (bus.enable) begin
        m_run  = 1'b1;
        m_dir  = bus.dir ? -1 : 1;
        m_left = DIV;
      end else if (bus.step_req) begin
        move(bus.dir ? -1 : 1, d);
      end
    end else begin
      if (!bus.enable) begin
        m_run = 1'b0;
      end else if (m_left == 0) begin
        m_left = DIV;
        move(bus.bounce_en ? m_dir : (bus.dir ? -1 : 1), d);
        m_dir = d;
      end else begin
        m_left--;
      end
    end
    exp_q.push_back({m_wrap, m_step, 8'(1 << m_pos)});
  endtask

  task automatic cycle();
    logic [9:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check_val("led_select", {24'd0, bus.led_select}, {24'd0, e[7:0]});
    check_val("step_pulse", {31'd0, bus.step_pulse}, {31'd0, e[8]});
    check_val("wrap_pulse", {31'd0, bus.wrap_pulse}, {31'd0, e[9]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset applied between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_led",  {24'd0, bus.led_select}, 32'h01);
    check_val("rst_step", {31'd0, bus.step_pulse}, 32'h0);
    check_val("rst_wrap", {31'd0, bus.wrap_pulse}, 32'h0);
    m_pos  = 0;
    m_run  = 1'b0;
    m_dir  = 1;
    m_left = DIV;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_left(input int target);
    for (int k = 0; k < 4 * (DIV + 1) && !(m_run && m_left == target); k++) cycle();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b1;
    bus.enable    = 1'b0;
    bus.dir       = 1'b0;
    bus.bounce_en = 1'b0;
    bus.step_req  = 1'b0;
    #2;
    do_reset();
    run(3);

    // Forward wrap-around run, one full lap plus a step.
    bus.enable = 1'b1;
    run(40);

    // Ping-pong run, enough for both end reversals.
    bus.bounce_en = 1'b1;
    run(70);

    // Drop enable exactly on a tick cycle, then resume.
    bus.bounce_en = 1'b0;
    wait_left(0);
    bus.enable = 1'b0;
    run(4);
    bus.enable = 1'b1;
    run(7);

    // Manual reverse step from position 0, then step_req while enabled.
    bus.enable = 1'b0;
    run(2);
    do_reset();
    bus.dir      = 1'b1;
    bus.step_req = 1'b1;
    cycle();
    bus.step_req = 1'b0;
    run(2);
    bus.enable   = 1'b1;
    bus.step_req = 1'b1;
    run(3);
    bus.step_req = 1'b0;

    // Forward run reversed by dir two cycles ahead of a tick.
    bus.dir = 1'b0;
    run(20);
    wait_left(2);
    bus.dir = 1'b1;
    run(25);

    // Reset in the middle of a run.
    do_reset();
    bus.enable = 1'b1;
    bus.dir    = 1'b0;
    run(8);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 9) == 0)  bus.dir = ~bus.dir;
      if ($urandom_range(0, 29) == 0) bus.bounce_en = ~bus.bounce_en;
      bus.step_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
